// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state and owner encodings for the shared memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rerr_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                proto_err_o
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                we_q, we_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                perr_q, perr_d;
    logic                idle, done, abort, rsp;

    always_comb begin
        idle     = state_q == ARB_IDLE;
        ls_gnt_o = idle & ls_req_i;
        if_gnt_o = idle & if_req_i & ~ls_req_i;
        done     = (state_q == ARB_RESP) & mem_rvalid_i;
        // a grant or response arriving on the expiry cycle takes precedence over the abort
        abort    = (TIMEOUT > 0) && !idle && cnt_q == LAST &&
                   !(state_q == ARB_REQ ? mem_gnt_i : mem_rvalid_i);
        rsp         = done | abort;
        if_rvalid_o = rsp & (owner_q == OWN_IF);
        ls_rvalid_o = rsp & (owner_q == OWN_LS);
        rerr_o      = abort;
        rdata_o     = done ? mem_rdata_i : '0;
        perr_d   = perr_q | (mem_rvalid_i & (state_q != ARB_RESP));
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = (!idle && TIMEOUT > 0) ? cnt_q + CW'(1) : cnt_q;
        if (ls_gnt_o | if_gnt_o) begin
            state_d = ARB_REQ;
            owner_d = ls_gnt_o ? OWN_LS : OWN_IF;
            we_d    = ls_gnt_o & ls_we_i;
            be_d    = ls_gnt_o ? ls_be_i : '1;
            addr_d  = ls_gnt_o ? ls_addr_i : if_addr_i;
            wdata_d = ls_gnt_o ? ls_wdata_i : '0;
            cnt_d   = '0;
        end else if (rsp) begin
            state_d = ARB_IDLE;
        end else if (state_q == ARB_REQ && mem_gnt_i) begin
            state_d = ARB_RESP;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    assign mem_req_o   = state_q == ARB_REQ;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = !idle;
    assign proto_err_o = perr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshake, timeout and reset behaviour.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
    logic [3:0]  ls_be = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, rerr, mem_req, mem_we, busy, perr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, rdata;
    int          total = 0, bad = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
        .rdata_o(rdata), .rerr_o(rerr),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .proto_err_o(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_perr", 32'(perr), 0);
        tick;
        rstn = 1'b1;
        tick;
        // 1: single fetch
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("t1_if_gnt", 32'(if_gnt), 1);
        chk("t1_ls_gnt", 32'(ls_gnt), 0);
        chk("t1_busy0", 32'(busy), 0);
        tick;
        if_req = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("t1_busy1", 32'(busy), 1);
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_we", 32'(mem_we), 0);
        chk("t1_mem_be", 32'(mem_be), 32'hF);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0051_3093;
        #1;
        chk("t1_mem_req_off", 32'(mem_req), 0);
        chk("t1_if_rvalid", 32'(if_rvalid), 1);
        chk("t1_ls_rvalid", 32'(ls_rvalid), 0);
        chk("t1_rdata", rdata, 32'h0051_3093);
        chk("t1_rerr", 32'(rerr), 0);
        chk("t1_busy2", 32'(busy), 1);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk("t1_idle", 32'(busy), 0);
        chk("t1_rvalid_off", 32'(if_rvalid), 0);
        chk("t1_rdata_zero", rdata, 0);
        // 2: tie, LS wins, IF follows
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h100;
        #1;
        chk("t2_ls_gnt", 32'(ls_gnt), 1);
        chk("t2_if_gnt", 32'(if_gnt), 0);
        tick;
        ls_req = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("t2_addr_ls", mem_addr, 32'h100);
        chk("t2_if_wait", 32'(if_gnt), 0);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk("t2_ls_rvalid", 32'(ls_rvalid), 1);
        chk("t2_if_rvalid0", 32'(if_rvalid), 0);
        chk("t2_rdata_ls", rdata, 32'hCAFE_0001);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk("t2_if_gnt", 32'(if_gnt), 1);
        tick;
        if_req = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("t2_addr_if", mem_addr, 32'h20);
        chk("t2_be_if", 32'(mem_be), 32'hF);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        #1;
        chk("t2_if_rvalid", 32'(if_rvalid), 1);
        chk("t2_rdata_if", rdata, 32'h0000_1234);
        tick;
        mem_rvalid = 1'b0;
        // 3: store with delayed memory grant
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h104; ls_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t3_ls_gnt", 32'(ls_gnt), 1);
        tick;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'hF; ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            #1;
            chk("t3_mem_req", 32'(mem_req), 1);
            chk("t3_we", 32'(mem_we), 1);
            chk("t3_be", 32'(mem_be), 32'h3);
            chk("t3_addr", mem_addr, 32'h104);
            chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
            tick;
        end
        mem_gnt = 1'b0;
        #1;
        chk("t3_req_drop", 32'(mem_req), 0);
        chk("t3_no_rvalid", 32'(ls_rvalid), 0);
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'h0;
        #1;
        chk("t3_ls_rvalid", 32'(ls_rvalid), 1);
        chk("t3_rerr", 32'(rerr), 0);
        tick;
        mem_rvalid = 1'b0;
        // 4: memory never grants, timeout after 8 cycles
        if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("t4_if_gnt", 32'(if_gnt), 1);
        tick;
        if_req = 1'b0;
        for (int c = 1; c < 8; c++) begin
            #1;
            chk("t4_wait_rvalid", 32'(if_rvalid), 0);
            chk("t4_wait_req", 32'(mem_req), 1);
            tick;
        end
        #1;
        chk("t4_abort_rvalid", 32'(if_rvalid), 1);
        chk("t4_abort_rerr", 32'(rerr), 1);
        chk("t4_abort_rdata", rdata, 0);
        tick;
        #1;
        chk("t4_idle", 32'(busy), 0);
        chk("t4_req_drop", 32'(mem_req), 0);
        chk("t4_perr0", 32'(perr), 0);
        mem_rvalid = 1'b1;
        #1;
        chk("t4_late_no_rvalid", 32'(if_rvalid), 0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk("t4_perr1", 32'(perr), 1);
        tick;
        #1;
        chk("t4_perr_sticky", 32'(perr), 1);
        // 5: asynchronous reset during RESP
        if_req = 1'b1; if_addr = 32'h50;
        #1;
        chk("t5_if_gnt", 32'(if_gnt), 1);
        tick;
        if_req = 1'b0; mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 1);
        rstn = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_req", 32'(mem_req), 0);
        chk("t5_rst_rvalid", 32'(if_rvalid), 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_perr", 32'(perr), 0);
        mem_rvalid = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
        if_req = 1'b1; if_addr = 32'h60;
        #1;
        chk("t5_new_gnt", 32'(if_gnt), 1);
        tick;
        if_req = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("t5_new_addr", mem_addr, 32'h60);
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_ABCD;
        #1;
        chk("t5_new_rvalid", 32'(if_rvalid), 1);
        chk("t5_new_rdata", rdata, 32'h0000_ABCD);
        chk("t5_new_rerr", 32'(rerr), 0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk("t5_final_idle", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
